// File: rtl/model_display_reader_pkg.sv
// model_disp_pkg: shared types, constants and helpers for the model display reader.
//   SIZE_DEFAULT  default window edge in pixels
//   TRANSPARENT   stored color that shows the background instead
//   timing_t      sync/blank/window bundle carried through the latency pipe
//   addr_width()  BRAM address width for a SIZE x SIZE bank
//   expand_color() 10-bit stored color {c[9:7], c[6:0]} -> 12-bit RGB
package model_disp_pkg;

  localparam int SIZE_DEFAULT = 64;
  localparam logic [9:0] TRANSPARENT = 10'h000;

  typedef struct packed {
    logic win;
    logic hsync;
    logic vsync;
    logic blank;
  } timing_t;

  // While reset the display is blanked, syncs idle, nothing in the window.
  localparam timing_t TIMING_RESET = '{win: 1'b0, hsync: 1'b0, vsync: 1'b0, blank: 1'b1};

  function automatic int addr_width(input int size);
    return $clog2(size * size);
  endfunction

  // The low bit of each widened field is zero-filled rather than replicated.
  function automatic logic [11:0] expand_color(input logic [9:0] c);
    return {c[9:7], 1'b0, c[6:0], 1'b0};
  endfunction

endpackage

// File: rtl/model_display_reader_sig_delay.sv
// sig_delay: fixed-depth shift pipe with asynchronous reset.
//   clk, rst   clock and async active-high reset (all stages load RESET_VAL)
//   d          value entering the pipe
//   q          value DEPTH cycles later
module sig_delay #(
  parameter int               WIDTH     = 1,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] pipe_r [DEPTH];

  // Shift register; reset clears every stage so no stale value leaks out after release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) pipe_r[i] <= RESET_VAL;
    end else begin
      pipe_r[0] <= d;
      for (int i = 1; i < DEPTH; i++) pipe_r[i] <= pipe_r[i-1];
    end
  end

  assign q = pipe_r[DEPTH-1];

endmodule

// File: rtl/model_display_reader.sv
// model_display_reader: reads the front bank of the double-buffered model color
// buffer in step with the VGA raster and composites it over a background color.
//   clk, rst                       pixel clock, async active-high reset
//   hcount_in, vcount_in           raster position
//   hsync_in, vsync_in, blank_in   raw timing
//   frame_done_in                  writer finished the back bank (1-cycle pulse)
//   rd_addr_out, rd_bank_out       BRAM read address / bank (front bank)
//   rd_data_in                     BRAM data, RD_LAT cycles after the address
//   wr_bank_out                    bank the writer targets (back bank)
//   swap_out, frame_drop_out       bank swap / dropped frame pulses
//   pixel_out, hsync_out, vsync_out, blank_out  outputs, RD_LAT+2 cycles after input
module model_display_reader
  import model_disp_pkg::*;
#(
  parameter int          SIZE     = SIZE_DEFAULT,
  parameter int          X0       = 480,
  parameter int          Y0       = 352,
  parameter int          RD_LAT   = 2,
  parameter logic [11:0] BG_COLOR = 12'h800
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [10:0]                  hcount_in,
  input  logic [9:0]                   vcount_in,
  input  logic                         hsync_in,
  input  logic                         vsync_in,
  input  logic                         blank_in,
  input  logic                         frame_done_in,
  output logic [addr_width(SIZE)-1:0]  rd_addr_out,
  output logic                         rd_bank_out,
  input  logic [9:0]                   rd_data_in,
  output logic                         wr_bank_out,
  output logic                         swap_out,
  output logic                         frame_drop_out,
  output logic [11:0]                  pixel_out,
  output logic                         hsync_out,
  output logic                         vsync_out,
  output logic                         blank_out
);

  localparam int          LOG    = $clog2(SIZE);
  localparam logic [10:0] X0_H   = 11'(X0);
  localparam logic [9:0]  Y0_V   = 10'(Y0);
  localparam logic [10:0] SIZE_H = 11'(SIZE);
  localparam logic [9:0]  SIZE_V = 10'(SIZE);

  // ---------------- window / address ----------------
  logic [10:0] dx_s;
  logic [9:0]  dy_s;
  logic        in_win_s;
  timing_t     timing_s;
  timing_t     timing_d_s;
  logic [addr_width(SIZE)-1:0] rd_addr_r;

  assign dx_s = hcount_in - X0_H;
  assign dy_s = vcount_in - Y0_V;
  // Offsets are unsigned, so "below X0/Y0" wraps large and fails the < SIZE test too;
  // the explicit >= keeps the test exact near the top of the counter range.
  assign in_win_s = (hcount_in >= X0_H) && (dx_s < SIZE_H) &&
                    (vcount_in >= Y0_V) && (dy_s < SIZE_V);

  // Stage 0 address register (row-major, SIZE is a power of two).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_addr_r <= '0;
    else     rd_addr_r <= {dy_s[LOG-1:0], dx_s[LOG-1:0]};
  end

  assign rd_addr_out = rd_addr_r;

  // Timing bundle rides alongside the BRAM read: stage 0 plus RD_LAT read cycles.
  assign timing_s = '{win: in_win_s, hsync: hsync_in, vsync: vsync_in, blank: blank_in};

  sig_delay #(
    .WIDTH     ($bits(timing_t)),
    .DEPTH     (RD_LAT + 1),
    .RESET_VAL (TIMING_RESET)
  ) u_timing_delay (
    .clk (clk),
    .rst (rst),
    .d   (timing_s),
    .q   (timing_d_s)
  );

  // ---------------- output compositing ----------------
  logic [11:0] pix_next_s;
  logic [11:0] pixel_r;
  logic        hsync_r;
  logic        vsync_r;
  logic        blank_r;

  // Pixel select: blank wins, then window with transparency, else background.
  always_comb begin
    pix_next_s = BG_COLOR;
    if (timing_d_s.blank) begin
      pix_next_s = 12'h000;
    end else if (timing_d_s.win && (rd_data_in != TRANSPARENT)) begin
      pix_next_s = expand_color(rd_data_in);
    end else begin
      pix_next_s = BG_COLOR;
    end
  end

  // Output register for pixel and the matched timing signals.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pixel_r <= 12'h000;
      hsync_r <= 1'b0;
      vsync_r <= 1'b0;
      blank_r <= 1'b1;
    end else begin
      pixel_r <= pix_next_s;
      hsync_r <= timing_d_s.hsync;
      vsync_r <= timing_d_s.vsync;
      blank_r <= timing_d_s.blank;
    end
  end

  assign pixel_out = pixel_r;
  assign hsync_out = hsync_r;
  assign vsync_out = vsync_r;
  assign blank_out = blank_r;

  // ---------------- bank swap FSM ----------------
  logic front_bank_r;
  logic pending_r;
  logic vsync_prev_r;
  logic swap_r;
  logic drop_r;
  logic vs_rise_s;
  logic swap_s;
  logic drop_s;
  logic front_next_s;
  logic pending_next_s;

  assign vs_rise_s = vsync_in && !vsync_prev_r;

  // State register: bank/pending state, vsync edge history and the registered pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      front_bank_r <= 1'b0;
      pending_r    <= 1'b0;
      vsync_prev_r <= 1'b0;
      swap_r       <= 1'b0;
      drop_r       <= 1'b0;
    end else begin
      front_bank_r <= front_next_s;
      pending_r    <= pending_next_s;
      vsync_prev_r <= vsync_in;
      swap_r       <= swap_s;
      drop_r       <= drop_s;
    end
  end

  // Event decode: a done arriving on the swap edge is consumed, never dropped.
  always_comb begin
    swap_s = 1'b0;
    drop_s = 1'b0;
    if (vs_rise_s && (pending_r || frame_done_in)) begin
      swap_s = 1'b1;
    end else begin
      swap_s = 1'b0;
    end
    if (frame_done_in && pending_r && !vs_rise_s) begin
      drop_s = 1'b1;
    end else begin
      drop_s = 1'b0;
    end
  end

  // Next-state: swap toggles the front bank and clears pending; a done otherwise sets it.
  always_comb begin
    front_next_s   = front_bank_r;
    pending_next_s = pending_r;
    if (swap_s) begin
      front_next_s   = ~front_bank_r;
      pending_next_s = 1'b0;
    end else if (frame_done_in) begin
      pending_next_s = 1'b1;
    end else begin
      pending_next_s = pending_r;
    end
  end

  assign rd_bank_out    = front_bank_r;
  assign wr_bank_out    = ~front_bank_r;
  assign swap_out       = swap_r;
  assign frame_drop_out = drop_r;

endmodule

// File: tb/tb_model_display_reader.sv
module tb_model_display_reader;

  logic        clk;
  logic        rst;
  logic [10:0] hcount_in;
  logic [9:0]  vcount_in;
  logic        hsync_in, vsync_in, blank_in, frame_done_in;
  logic [11:0] rd_addr_out;
  logic        rd_bank_out, wr_bank_out, swap_out, frame_drop_out;
  logic [9:0]  rd_data_in;
  logic [11:0] pixel_out;
  logic        hsync_out, vsync_out, blank_out;

  model_display_reader dut (
    .clk(clk), .rst(rst),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .blank_in(blank_in),
    .frame_done_in(frame_done_in),
    .rd_addr_out(rd_addr_out), .rd_bank_out(rd_bank_out), .rd_data_in(rd_data_in),
    .wr_bank_out(wr_bank_out), .swap_out(swap_out), .frame_drop_out(frame_drop_out),
    .pixel_out(pixel_out), .hsync_out(hsync_out), .vsync_out(vsync_out), .blank_out(blank_out)
  );

  always #5 clk = ~clk;

  // BRAM model: two banks, read latency 2.
  logic [9:0] mem [2][4096];
  logic [9:0] bram_q;
  always @(posedge clk) begin
    bram_q     <= mem[rd_bank_out][rd_addr_out];
    rd_data_in <= bram_q;
  end

  // ---------------- reference model ----------------
  typedef struct {
    logic [11:0] pix;
    logic hs, vs, bl;
  } exp_t;

  exp_t pq[$];
  exp_t r_e;
  int   n_cmp, n_err;
  // current expectations (valid right after drive returns)
  logic [11:0] c_pix;
  logic c_hs, c_vs, c_bl;
  int   cs_addr;
  bit   cs_win, cs_swap, cs_drop, cs_bank;
  // stored one-cycle expectations for the vector just applied
  int   s1_addr;
  bit   s1_win, s1_swap, s1_drop, s1_bank;
  // swap state by the rules
  bit   m_bank, m_pend, m_prev_vs;

  function automatic bit ref_win(input int h, input int v);
    return (h >= 480) && (h < 544) && (v >= 352) && (v < 416);
  endfunction

  function automatic logic [11:0] ref_pixel(input int h, input int v, input bit bl, input bit bank);
    int c;
    if (bl) return 12'h000;
    if (!ref_win(h, v)) return 12'h800;
    c = int'(mem[bank][(v - 352) * 64 + (h - 480)]);
    if (c == 0) return 12'h800;
    return 12'((c / 128) * 512 + (c % 128) * 2);
  endfunction

  task automatic drive(input int h, input int v, input bit hs, input bit vs, input bit bl, input bit fd);
    exp_t e;
    bit   rise;
    @(negedge clk);
    if (rst) begin
      c_pix = 12'h000; c_hs = 1'b0; c_vs = 1'b0; c_bl = 1'b1;
      cs_addr = 0; cs_win = 1'b0; cs_swap = 1'b0; cs_drop = 1'b0; cs_bank = 1'b0;
    end else begin
      e = pq.pop_front();
      c_pix = e.pix; c_hs = e.hs; c_vs = e.vs; c_bl = e.bl;
      cs_addr = s1_addr; cs_win = s1_win; cs_swap = s1_swap; cs_drop = s1_drop; cs_bank = s1_bank;
    end
    hcount_in = 11'(h); vcount_in = 10'(v);
    hsync_in = hs; vsync_in = vs; blank_in = bl; frame_done_in = fd;
    if (rst) begin
      m_bank = 1'b0; m_pend = 1'b0; m_prev_vs = 1'b0;
      s1_addr = 0; s1_win = 1'b0; s1_swap = 1'b0; s1_drop = 1'b0; s1_bank = 1'b0;
      pq.delete();
      repeat (4) pq.push_back(r_e);
    end else begin
      rise = vs && !m_prev_vs;
      m_prev_vs = vs;
      s1_swap = 1'b0; s1_drop = 1'b0;
      if (rise && (m_pend || fd)) begin
        m_bank = !m_bank; m_pend = 1'b0; s1_swap = 1'b1;
      end else begin
        if (fd && m_pend) s1_drop = 1'b1;
        if (fd) m_pend = 1'b1;
      end
      s1_bank = m_bank;
      s1_win  = ref_win(h, v);
      s1_addr = (v - 352) * 64 + (h - 480);
      e.pix = ref_pixel(h, v, bl, m_bank);
      e.hs = hs; e.vs = vs; e.bl = bl;
      pq.push_back(e);
    end
  endtask

  task automatic idle();
    drive(0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) idle();
    n_cmp++;
    if ({pixel_out, hsync_out, vsync_out, blank_out} !== {12'h000, 3'b001}) begin
      n_err++; $display("FAIL reset_outputs got %h/%b%b%b exp 000/001", pixel_out, hsync_out, vsync_out, blank_out);
    end
    n_cmp++;
    if ({rd_addr_out, rd_bank_out, wr_bank_out, swap_out, frame_drop_out} !== {12'h000, 4'b0100}) begin
      n_err++; $display("FAIL reset_ctrl got addr=%h bank=%b wr=%b swap=%b drop=%b", rd_addr_out, rd_bank_out, wr_bank_out, swap_out, frame_drop_out);
    end
    @(posedge clk); #2 rst = 1'b0;
  endtask

  task automatic test_origin();
    mem[0][0] = 10'h3FF;
    drive(480, 352, 1'b0, 1'b0, 1'b0, 1'b0);
    idle();
    n_cmp++;
    if (rd_addr_out !== 12'd0) begin n_err++; $display("FAIL origin_addr got %0d exp 0", rd_addr_out); end
    repeat (3) idle();
    n_cmp++;
    if (pixel_out !== 12'hEFE) begin n_err++; $display("FAIL origin_pixel got %h exp efe", pixel_out); end
  endtask

  task automatic test_edges();
    logic [11:0] exp_a;
    drive(543, 415, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_a = ref_pixel(543, 415, 1'b0, 1'b0);
    drive(544, 415, 1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (rd_addr_out !== 12'd4095) begin n_err++; $display("FAIL edge_addr got %0d exp 4095", rd_addr_out); end
    drive(479, 352, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(500, 360, 1'b0, 1'b0, 1'b1, 1'b0);
    idle();
    n_cmp++;
    if (pixel_out !== exp_a) begin n_err++; $display("FAIL edge_corner got %h exp %h", pixel_out, exp_a); end
    idle();
    n_cmp++;
    if (pixel_out !== 12'h800) begin n_err++; $display("FAIL edge_right got %h exp 800", pixel_out); end
    idle();
    n_cmp++;
    if (pixel_out !== 12'h800) begin n_err++; $display("FAIL edge_left got %h exp 800", pixel_out); end
    idle();
    n_cmp++;
    if (pixel_out !== 12'h000) begin n_err++; $display("FAIL edge_blank got %h exp 000", pixel_out); end
  endtask

  task automatic test_transparency();
    mem[0][5] = 10'h000;
    mem[0][6] = 10'h001;
    drive(485, 352, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(486, 352, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) idle();
    n_cmp++;
    if (pixel_out !== 12'h800) begin n_err++; $display("FAIL transparent got %h exp 800", pixel_out); end
    idle();
    n_cmp++;
    if (pixel_out !== 12'h002) begin n_err++; $display("FAIL color_001 got %h exp 002", pixel_out); end
  endtask

  task automatic test_random(input int n);
    for (int i = 0; i < n; i++) begin
      drive(int'($urandom_range(560, 470)), int'($urandom_range(425, 340)),
            1'($urandom), 1'($urandom), ($urandom_range(3) == 0), 1'b0);
      n_cmp++;
      if (pixel_out !== c_pix) begin n_err++; $display("FAIL rand_pixel got %h exp %h", pixel_out, c_pix); end
      n_cmp++;
      if ({hsync_out, vsync_out, blank_out} !== {c_hs, c_vs, c_bl}) begin
        n_err++; $display("FAIL rand_timing got %b%b%b exp %b%b%b", hsync_out, vsync_out, blank_out, c_hs, c_vs, c_bl);
      end
      if (cs_win) begin
        n_cmp++;
        if (rd_addr_out !== 12'(cs_addr)) begin n_err++; $display("FAIL rand_addr got %0d exp %0d", rd_addr_out, cs_addr); end
      end
      n_cmp++;
      if ({swap_out, frame_drop_out, rd_bank_out} !== {cs_swap, cs_drop, cs_bank}) begin
        n_err++; $display("FAIL rand_ctrl got %b%b%b exp %b%b%b", swap_out, frame_drop_out, rd_bank_out, cs_swap, cs_drop, cs_bank);
      end
    end
  endtask

  task automatic test_swap();
    logic [15:0] vs_tab [3];
    logic [15:0] fd_tab [3];
    int          drop_tab [3];
    logic [15:0] vp, fp;
    int          n_sw, n_dr;
    bit          bank0;
    vs_tab[0] = 16'h38E0; fd_tab[0] = 16'h0004; drop_tab[0] = 0;
    vs_tab[1] = 16'h01C0; fd_tab[1] = 16'h000A; drop_tab[1] = 1;
    vs_tab[2] = 16'h0070; fd_tab[2] = 16'h0010; drop_tab[2] = 0;
    for (int s = 0; s < 3; s++) begin
      vp = vs_tab[s]; fp = fd_tab[s];
      n_sw = 0; n_dr = 0;
      idle();
      bank0 = rd_bank_out;
      for (int i = 0; i < 18; i++) begin
        if (i < 16) drive(0, 0, 1'b0, vp[i], 1'b1, fp[i]);
        else        idle();
        n_sw += int'(swap_out);
        n_dr += int'(frame_drop_out);
        n_cmp++;
        if ({swap_out, frame_drop_out, rd_bank_out, wr_bank_out} !== {cs_swap, cs_drop, cs_bank, !cs_bank}) begin
          n_err++; $display("FAIL swap%0d_cyc%0d got sw=%b dr=%b rb=%b wb=%b exp %b %b %b %b", s, i,
                            swap_out, frame_drop_out, rd_bank_out, wr_bank_out, cs_swap, cs_drop, cs_bank, !cs_bank);
        end
      end
      n_cmp++;
      if (n_sw != 1 || n_dr != drop_tab[s]) begin
        n_err++; $display("FAIL swap%0d_pulses got swaps=%0d drops=%0d exp 1 %0d", s, n_sw, n_dr, drop_tab[s]);
      end
      n_cmp++;
      if (rd_bank_out !== !bank0 || wr_bank_out !== bank0) begin
        n_err++; $display("FAIL swap%0d_bank got rd=%b wr=%b exp rd=%b wr=%b", s, rd_bank_out, wr_bank_out, !bank0, bank0);
      end
    end
  endtask

  task automatic test_reset_midline();
    for (int i = 0; i < 8; i++) drive(480 + i, 360, 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #3 rst = 1'b1;
    #1;
    n_cmp++;
    if ({pixel_out, hsync_out, vsync_out, blank_out} !== {12'h000, 3'b001}) begin
      n_err++; $display("FAIL midreset_outputs got %h/%b%b%b exp 000/001", pixel_out, hsync_out, vsync_out, blank_out);
    end
    n_cmp++;
    if ({rd_addr_out, rd_bank_out, wr_bank_out, swap_out, frame_drop_out} !== {12'h000, 4'b0100}) begin
      n_err++; $display("FAIL midreset_ctrl got addr=%h bank=%b wr=%b", rd_addr_out, rd_bank_out, wr_bank_out);
    end
    for (int i = 0; i < 3; i++) begin
      drive(490 + i, 370, 1'b1, 1'b1, 1'b0, 1'b0);
      n_cmp++;
      if ({pixel_out, hsync_out, vsync_out, blank_out} !== {c_pix, c_hs, c_vs, c_bl}) begin
        n_err++; $display("FAIL midreset_hold got %h/%b%b%b exp %h/%b%b%b", pixel_out, hsync_out, vsync_out, blank_out, c_pix, c_hs, c_vs, c_bl);
      end
    end
    @(posedge clk); #2 rst = 1'b0;
    drive(500, 370, 1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (rd_bank_out !== 1'b0 || wr_bank_out !== 1'b1) begin
      n_err++; $display("FAIL midreset_bank got rd=%b wr=%b exp 0 1", rd_bank_out, wr_bank_out);
    end
    test_random(200);
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1;
    hcount_in = 11'd0; vcount_in = 10'd0;
    hsync_in = 1'b0; vsync_in = 1'b0; blank_in = 1'b1; frame_done_in = 1'b0;
    n_cmp = 0; n_err = 0;
    r_e.pix = 12'h000; r_e.hs = 1'b0; r_e.vs = 1'b0; r_e.bl = 1'b1;
    repeat (4) pq.push_back(r_e);
    m_bank = 1'b0; m_pend = 1'b0; m_prev_vs = 1'b0;
    s1_addr = 0; s1_win = 1'b0; s1_swap = 1'b0; s1_drop = 1'b0; s1_bank = 1'b0;
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < 4096; i++)
        mem[b][i] = ($urandom_range(7) == 0) ? 10'h000 : 10'($urandom);

    test_reset();
    test_origin();
    test_edges();
    test_transparency();
    test_random(300);
    test_swap();
    test_reset_midline();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/model_display_reader.md
# model_display_reader

Display-side reader for the double-buffered 64x64 model color buffer. The rasterize/zbuffer path writes the back bank; this block reads the front bank in step with the VGA raster on the 65 MHz pixel clock. It expands 10-bit stored color to 12-bit RGB, composites the window over a background color, and delays sync/blank to match. Bank swaps happen only at vsync, on a frame-done handshake from the writer.

## Interface
Parameters:
- SIZE, 64: model window edge in pixels; power of two.
- X0, 480: first active hcount of the window.
- Y0, 352: first active vcount of the window.
- RD_LAT, 2: BRAM read latency in cycles, from address to data; 2 for HIGH_PERFORMANCE.
- BG_COLOR, 12'h800: 12-bit RGB outside the window and for transparent pixels.

Ports:
- clk  in  1  pixel clock (65 MHz domain).
- rst  in  1  asynchronous, active-high reset.
- hcount_in  in  11  raster x from the vga timing generator.
- vcount_in  in  10  raster y.
- hsync_in, vsync_in, blank_in  in  1 each  raw, active-high timing signals.
- frame_done_in  in  1  one-cycle pulse: the writer has finished the back bank.
- rd_addr_out  out  log2(SIZE*SIZE)  BRAM read address within the bank.
- rd_bank_out  out  1  bank being read; equals front_bank.
- rd_data_in  in  10  BRAM read data, format {c[9:7], c[6:0]}.
- wr_bank_out  out  1  bank the writer must target; always ~front_bank.
- swap_out  out  1  one-cycle pulse: banks swapped, writer may start the next frame.
- frame_drop_out  out  1  one-cycle pulse: frame_done_in arrived while a swap was already pending.
- pixel_out  out  12  RGB to pins; 0 while blanked.
- hsync_out, vsync_out, blank_out  out  1 each  timing delayed to match pixel_out.

## Operation
- Window test: in_win = (X0 <= hcount_in <= X0+SIZE-1) and (Y0 <= vcount_in <= Y0+SIZE-1). The window is exactly SIZE wide and SIZE tall.
- Address: ((vcount_in - Y0) << log2(SIZE)) | (hcount_in - X0), truncated to the address width.
- Outside the window the address value is don't-care. The bench checks the address only when in_win is true.
- Color expansion: rgb = {c[9:7], 1'b0, c[6:0], 1'b0}.
- Transparency: if c == 10'h000 inside the window, output BG_COLOR.
- Output selection: if blank is set, pixel_out = 12'h000; otherwise in_win ? expanded color : BG_COLOR. blank takes priority over in_win.
- Swap state is two bits: front_bank and pending.
  - frame_done_in sets pending.
  - If pending is already 1 when frame_done_in arrives, pulse frame_drop_out; pending stays 1.
  - Swap point: rising edge of vsync_in, detected with a registered previous value.
  - At the swap point, if pending (or frame_done_in in the same cycle): toggle front_bank, pulse swap_out, clear pending.
  - If frame_done_in coincides with the swap point, it is consumed by that swap and no drop is flagged.
- Reset values: front_bank=0, pending=0, swap_out=0, frame_drop_out=0, rd_addr_out=0, pixel_out=0, hsync_out=0, vsync_out=0, blank_out=1. All delay-pipe stages are cleared to these values.
- Reset mid-frame: the outputs must not glitch to non-reset values while rst is high. The first valid pixel appears L cycles after release.

## Timing
- Stage 0, registered: rd_addr_out, in_win, hsync, vsync, blank, one cycle after the input.
- Data arrives RD_LAT cycles after the address.
- The output register adds 1 cycle.
- Total latency L = RD_LAT + 2 (4 by default), from hcount_in/sync inputs to pixel_out/sync outputs.
- hsync, vsync, blank and in_win travel through an identical delay of L.
- rd_bank_out changes only at the swap point, i.e. one cycle after the vsync_in rising edge.
- swap_out is high for exactly one cycle, coincident with the front_bank change.

## Structure
- Package model_disp_pkg holds:
  - SIZE_DEFAULT and the address width function;
  - the color expansion function expand_color(logic [9:0]) -> logic [11:0];
  - the TRANSPARENT constant, 10'h000.
- Sub-module sig_delay (parameters WIDTH, DEPTH, RESET_VAL): a shift pipe with async reset. It is used for the timing bundle and for in_win.
- Top of this block: window/address logic, the swap FSM, and the output register.

## Test plan
- hcount=480, vcount=352, with BRAM model returning 10'h3FF -> rd_addr_out=0 after 1 cycle; pixel_out=12'hEFE after 4 cycles.
- Window edges: (543,415) -> addr 4095; (544,415) and (479,352) -> BG_COLOR 12'h800; blank_in=1 inside the window -> pixel_out=0.
- rd_data_in=10'h000 inside the window -> pixel_out=12'h800; rd_data_in=10'h001 -> 12'h002.
- frame_done_in pulse mid-frame, then a vsync rising edge -> swap_out pulses once; rd_bank_out 0->1 and wr_bank_out 1->0; the next vsync with no done -> no swap.
- Two frame_done_in pulses before a vsync -> one frame_drop_out pulse and a single swap; frame_done_in on the same cycle as the vsync edge -> swap, no drop.
- Assert rst mid-line -> all outputs at reset values immediately, with no clock needed; after release, outputs track the input with latency 4 and front_bank=0.
